// File: rtl/fm7_clk_pkg.sv
// ----------------------------------------------------------------------------
// fm7_clk_pkg
// Shared types and constants for the FM-7 reset sequencer and clock-enable
// generation running on the 48 MHz PLL clock.
//   seq_state_t    : reset sequencer states
//   *_DEF          : default timing / divider / fractional ratio values
//   *_W            : counter and accumulator widths
//   in_ce_window() : true in the states where clock enables may run
// ----------------------------------------------------------------------------
package fm7_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  // 100 us of lock at 48 MHz before the reset hold starts
  localparam int LOCK_STABLE_DEF = 4800;
  localparam int RST_HOLD_DEF    = 48;

  // 48 MHz / 24 = 2.0 MHz, 48 MHz / 40 = 1.2 MHz
  localparam int DIV_FAST_DEF    = 24;
  localparam int DIV_SLOW_DEF    = 40;

  // 48 MHz * 192 / 7500 = 1.2288 MHz
  localparam int SND_INC_DEF     = 192;
  localparam int SND_MOD_DEF     = 7500;

  // Sequencer counter covers LOCK_STABLE / RST_HOLD up to 65535 cycles
  localparam int SEQ_CNT_W       = 16;
  localparam int CPU_DIV_W       = 6;
  localparam int SND_ACC_W       = 13;

  // Enables only run while the core is held in reset or running, so logic
  // gated by them still observes the reset edge.
  function automatic logic in_ce_window(input seq_state_t s);
    return (s == HOLD) || (s == RUN);
  endfunction

endpackage

// File: rtl/fm7_frac_ce.sv
// ----------------------------------------------------------------------------
// fm7_frac_ce
// Generic fractional clock-enable generator: produces INC pulses every MOD
// enabled cycles using a phase accumulator, so pulse spacing is either
// floor(MOD/INC) or ceil(MOD/INC) cycles.
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   clr   in   restart the phase (accumulator to zero, no pulse)
//   en    in   advance the accumulator this cycle
//   ce    out  registered one-cycle enable pulse
// ----------------------------------------------------------------------------
module fm7_frac_ce #(
  parameter int INC   = 192,
  parameter int MOD   = 7500,
  parameter int ACC_W = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic ce
);

  // One extra bit so acc + INC never overflows before the compare
  localparam logic [ACC_W:0] INC_EXT = (ACC_W + 1)'(INC);
  localparam logic [ACC_W:0] MOD_EXT = (ACC_W + 1)'(MOD);

  logic [ACC_W-1:0] acc_r;
  logic             ce_r;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             wrap_s;

  // Next accumulator value and wrap detection
  always_comb begin
    sum_s     = {1'b0, acc_r} + INC_EXT;
    wrap_s    = 1'b0;
    acc_nxt_s = sum_s[ACC_W-1:0];
    if (sum_s >= MOD_EXT) begin
      wrap_s    = 1'b1;
      acc_nxt_s = ACC_W'(sum_s - MOD_EXT);
    end else begin
      wrap_s    = 1'b0;
      acc_nxt_s = sum_s[ACC_W-1:0];
    end
  end

  // Accumulator and registered enable pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
      ce_r  <= 1'b0;
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
      ce_r  <= 1'b0;
    end else if (en) begin
      acc_r <= acc_nxt_s;
      ce_r  <= wrap_s;
    end else begin
      acc_r <= acc_r;
      ce_r  <= 1'b0;
    end
  end

  assign ce = ce_r;

endmodule

// File: rtl/fm7_reset_ce_gen.sv
// ----------------------------------------------------------------------------
// fm7_reset_ce_gen
// Reset sequencer and clock-enable generator downstream of the system PLL.
// Qualifies the PLL lock, holds the FM-7 core in reset until the lock has
// been stable, then releases it and generates CPU and PSG clock enables.
// Ports:
//   clk_sys    in   48 MHz PLL clock, the only clock
//   rst_n      in   synchronous active-low reset
//   pll_locked in   asynchronous PLL lock flag (synchronised here)
//   slow       in   1 = CPU at DIV_SLOW, 0 = CPU at DIV_FAST
//   cold_req   in   single-cycle core reset request
//   sys_rst_n  out  registered active-low core reset
//   cpu_ce     out  one-cycle CPU enable pulse
//   snd_ce     out  one-cycle PSG enable pulse
//   running    out  high while the sequencer is in RUN
// ----------------------------------------------------------------------------
module fm7_reset_ce_gen
  import fm7_clk_pkg::*;
#(
  parameter int LOCK_STABLE = LOCK_STABLE_DEF,
  parameter int RST_HOLD    = RST_HOLD_DEF,
  parameter int DIV_FAST    = DIV_FAST_DEF,
  parameter int DIV_SLOW    = DIV_SLOW_DEF,
  parameter int SND_INC     = SND_INC_DEF,
  parameter int SND_MOD     = SND_MOD_DEF
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic slow,
  input  logic cold_req,
  output logic sys_rst_n,
  output logic cpu_ce,
  output logic snd_ce,
  output logic running
);

  localparam logic [SEQ_CNT_W-1:0] SEQ_ZERO    = {SEQ_CNT_W{1'b0}};
  localparam logic [SEQ_CNT_W-1:0] SEQ_ONE     = SEQ_CNT_W'(1);
  localparam logic [SEQ_CNT_W-1:0] STABLE_LAST = SEQ_CNT_W'(LOCK_STABLE - 1);
  localparam logic [SEQ_CNT_W-1:0] HOLD_LAST   = SEQ_CNT_W'(RST_HOLD - 1);
  localparam logic [CPU_DIV_W-1:0] DIV_ZERO    = {CPU_DIV_W{1'b0}};
  localparam logic [CPU_DIV_W-1:0] DIV_ONE     = CPU_DIV_W'(1);
  localparam logic [CPU_DIV_W-1:0] FAST_LAST   = CPU_DIV_W'(DIV_FAST - 1);
  localparam logic [CPU_DIV_W-1:0] SLOW_LAST   = CPU_DIV_W'(DIV_SLOW - 1);

  logic                 lk_meta_r;
  logic                 lk_r;
  seq_state_t           state_r;
  seq_state_t           state_nxt_s;
  logic [SEQ_CNT_W-1:0] seq_cnt_r;
  logic [SEQ_CNT_W-1:0] seq_cnt_nxt_s;
  logic                 enter_hold_s;
  logic                 ce_win_s;
  logic [CPU_DIV_W-1:0] cpu_cnt_r;
  logic [CPU_DIV_W-1:0] cpu_last_r;
  logic [CPU_DIV_W-1:0] cpu_last_sel_s;
  logic                 cpu_ce_r;
  logic                 sys_rst_n_r;
  logic                 running_r;

  // Two-flop synchroniser for the asynchronous PLL lock flag
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      lk_meta_r <= 1'b0;
      lk_r      <= 1'b0;
    end else begin
      lk_meta_r <= pll_locked;
      lk_r      <= lk_meta_r;
    end
  end

  // Sequencer next state; loss of lock overrides everything, including cold_req
  always_comb begin
    state_nxt_s   = state_r;
    seq_cnt_nxt_s = seq_cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        seq_cnt_nxt_s = SEQ_ZERO;
        if (lk_r) begin
          state_nxt_s = STABLE;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lk_r) begin
          state_nxt_s   = WAIT_LOCK;
          seq_cnt_nxt_s = SEQ_ZERO;
        end else if (seq_cnt_r == STABLE_LAST) begin
          state_nxt_s   = HOLD;
          seq_cnt_nxt_s = SEQ_ZERO;
        end else begin
          state_nxt_s   = STABLE;
          seq_cnt_nxt_s = seq_cnt_r + SEQ_ONE;
        end
      end
      HOLD: begin
        if (!lk_r) begin
          state_nxt_s   = WAIT_LOCK;
          seq_cnt_nxt_s = SEQ_ZERO;
        end else if (cold_req) begin
          // A fresh request restarts the full hold from this cycle
          state_nxt_s   = HOLD;
          seq_cnt_nxt_s = SEQ_ZERO;
        end else if (seq_cnt_r == HOLD_LAST) begin
          state_nxt_s   = RUN;
          seq_cnt_nxt_s = SEQ_ZERO;
        end else begin
          state_nxt_s   = HOLD;
          seq_cnt_nxt_s = seq_cnt_r + SEQ_ONE;
        end
      end
      RUN: begin
        seq_cnt_nxt_s = SEQ_ZERO;
        if (!lk_r) begin
          state_nxt_s = WAIT_LOCK;
        end else if (cold_req) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s   = WAIT_LOCK;
        seq_cnt_nxt_s = SEQ_ZERO;
      end
    endcase
  end

  // Only a transition into HOLD restarts the enable phases; a reload does not
  assign enter_hold_s   = (state_nxt_s == HOLD) && (state_r != HOLD);
  assign ce_win_s       = in_ce_window(state_r);
  assign cpu_last_sel_s = slow ? SLOW_LAST : FAST_LAST;

  // Sequencer state and cycle counter registers
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_r   <= WAIT_LOCK;
      seq_cnt_r <= SEQ_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      seq_cnt_r <= seq_cnt_nxt_s;
    end
  end

  // CPU divider; the divisor is only re-sampled at a wrap so a change of
  // 'slow' takes effect cleanly on the next full period
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cpu_cnt_r  <= DIV_ZERO;
      cpu_last_r <= FAST_LAST;
      cpu_ce_r   <= 1'b0;
    end else if (enter_hold_s) begin
      cpu_cnt_r  <= DIV_ZERO;
      cpu_last_r <= cpu_last_sel_s;
      cpu_ce_r   <= 1'b0;
    end else if (ce_win_s) begin
      if (cpu_cnt_r == cpu_last_r) begin
        cpu_cnt_r  <= DIV_ZERO;
        cpu_last_r <= cpu_last_sel_s;
        cpu_ce_r   <= 1'b1;
      end else begin
        cpu_cnt_r  <= cpu_cnt_r + DIV_ONE;
        cpu_last_r <= cpu_last_r;
        cpu_ce_r   <= 1'b0;
      end
    end else begin
      cpu_cnt_r  <= DIV_ZERO;
      cpu_last_r <= cpu_last_r;
      cpu_ce_r   <= 1'b0;
    end
  end

  // PSG enable from the fractional accumulator
  fm7_frac_ce #(
    .INC   (SND_INC),
    .MOD   (SND_MOD),
    .ACC_W (SND_ACC_W)
  ) u_snd_ce (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .clr   (enter_hold_s),
    .en    (ce_win_s),
    .ce    (snd_ce)
  );

  // Core reset and running flag, registered from the current state
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sys_rst_n_r <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      sys_rst_n_r <= (state_r == RUN);
      running_r   <= (state_r == RUN);
    end
  end

  assign sys_rst_n = sys_rst_n_r;
  assign running   = running_r;
  assign cpu_ce    = cpu_ce_r;

endmodule

// File: doc/fm7_reset_ce_gen.md
# fm7_reset_ce_gen

Reset sequencer and clock-enable generator sitting directly downstream of the system PLL. It runs on the PLL's 48 MHz output and qualifies the PLL `locked` flag. It holds the FM-7 core in reset until the lock is stable, then produces single-cycle clock enables for the main/sub CPU (2.0 or 1.2 MHz) and the PSG (1.2288 MHz, fractional). All core logic runs on one clock and is gated by these enables.

## Interface
Parameters:
- `LOCK_STABLE`, 4800: cycles `locked` must stay high before the reset hold starts (100 µs).
- `RST_HOLD`, 48: cycles `sys_rst_n` stays low with enables running.
- `DIV_FAST`, 24: CPU divider in fast mode (48/24 = 2.0 MHz).
- `DIV_SLOW`, 40: CPU divider in slow mode (1.2 MHz).
- `SND_INC`, 192 and `SND_MOD`, 7500: fractional PSG enable ratio (48 MHz × 192/7500 = 1.2288 MHz).

Ports:
- `clk_sys`  in  1  48 MHz from PLL `outclk_0`; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `pll_locked`  in  1  PLL lock flag; asynchronous, double-flop synchronised internally.
- `slow`  in  1  1 selects `DIV_SLOW`, 0 selects `DIV_FAST`.
- `cold_req`  in  1  single-cycle pulse requesting a core reset.
- `sys_rst_n`  out  1  core reset, active-low, registered.
- `cpu_ce`  out  1  one-cycle CPU enable pulse.
- `snd_ce`  out  1  one-cycle PSG enable pulse.
- `running`  out  1  high in state RUN.

## Operation
- Reset values (while `rst_n` = 0): `sys_rst_n` = 0, `cpu_ce` = 0, `snd_ce` = 0, `running` = 0. State is WAIT_LOCK. Synchroniser, counters and accumulator are cleared.
- `lk` is `pll_locked` after two `clk_sys` flops.
- States:
  - **WAIT_LOCK**: go to STABLE when `lk` = 1.
  - **STABLE**: count `LOCK_STABLE` cycles, then go to HOLD. If `lk` = 0, return to WAIT_LOCK.
  - **HOLD**: count `RST_HOLD` cycles, then go to RUN. Entering HOLD clears the CPU divider and the PSG accumulator.
  - **RUN**: `cold_req` goes to HOLD. There is no STABLE wait on this path.
- `lk` = 0 in any state forces WAIT_LOCK and has priority over `cold_req`.
- `cold_req` while already in HOLD reloads the HOLD counter.
- `cold_req` outside HOLD/RUN is ignored.
- Enables are active only in HOLD and RUN, so CE-gated logic sees reset edges. In WAIT_LOCK and STABLE both enables are forced to 0.
- CPU divider:
  - 6-bit counter; `cpu_ce` = 1 when count = DIV−1, after which the count wraps to 0.
  - The divisor is latched from `slow` only at the wrap. Changing `slow` mid-period never produces a short or long runt period.
- PSG enable:
  - 13-bit accumulator.
  - If acc + `SND_INC` ≥ `SND_MOD`: acc ← acc + `SND_INC` − `SND_MOD` and `snd_ce` = 1. Otherwise acc ← acc + `SND_INC`.
  - Result: exactly 192 pulses per 7500 cycles, spaced 39 or 40 cycles apart.
- `cpu_ce` and `snd_ce` may coincide; they are independent.

## Timing
- All outputs are registered.
- Lock-up latency: if `pll_locked` is first sampled high at edge k, `sys_rst_n` rises at edge k + 2 + `LOCK_STABLE` + `RST_HOLD` + 1.
- Lock loss: `pll_locked` low at edge k drives `sys_rst_n` = 0 and both enables = 0 at edge k+3. A one-cycle glitch is enough.
- `cold_req` at edge k in RUN: `sys_rst_n` = 0 from edge k+1 for `RST_HOLD` cycles.
- First `cpu_ce` comes DIV cycles after HOLD entry. First `snd_ce` comes 40 cycles after HOLD entry (ceil(7500/192)).
- `running` follows `sys_rst_n` in the same cycle.

## Structure
- Package `fm7_clk_pkg` holds:
  - the state enum (WAIT_LOCK, STABLE, HOLD, RUN);
  - default DIV_FAST/DIV_SLOW, SND_INC/SND_MOD;
  - counter width constants.
- Sub-module `fm7_frac_ce` is the generic accumulator enable generator (INC, MOD, clear input). It is reused later for the FDC and serial rates.
- Sequencer and CPU divider live in the top module.

## Test plan
1. `LOCK_STABLE`=8, `RST_HOLD`=4, `pll_locked` rises at edge 10 → `sys_rst_n` rises at edge 25. `cpu_ce` first pulses 24 cycles after HOLD entry.
2. RUN with `slow`=0, then `slow`=1 toggled 10 cycles into a period → that period ends at 24 cycles, following periods are 40 cycles, and no other spacing appears.
3. 7500 cycles in RUN → exactly 192 `snd_ce` pulses; every gap is 39 or 40 cycles.
4. `pll_locked` low for one cycle in RUN → `sys_rst_n`, `cpu_ce`, `snd_ce` are 0 three edges later, and the full sequence replays (15 cycles to release).
5. `cold_req` in RUN → `sys_rst_n` low next edge for exactly 4 cycles with `cpu_ce` running. A second `cold_req` mid-HOLD extends the hold to 4 cycles from that pulse.
6. `rst_n` low mid-STABLE → all outputs at reset values next edge. After release, the sequence restarts from WAIT_LOCK.
